// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl: sequencing controller for the 8-bit dice LFSR.
//
// On roll_req the external LFSR is stepped STEPS_PER_DRAW times per draw attempt.
// lfsr_num[2:0] is then rejection-sampled into a fair die value 1..6. After
// MAX_REJECT rejected samples, a raw 0 is forced to 1 and a raw 7 is forced to 6.
// Two dice are drawn per roll. seed_req reloads the LFSR with a zero-safe seed.
//
// Optional feature macro: DICE_FREERUN_EN. When it is defined, the LFSR also
// advances while the controller is IDLE.
//
// Ports:
//   clock          system clock, rising edge
//   resetn         asynchronous active-low reset
//   seed_req       reseed pulse; seed_in is sampled with it
//   seed_in        seed value
//   roll_req       roll start pulse
//   lfsr_num       current (registered) LFSR state
//   lfsr_clock_en  LFSR advance enable
//   lfsr_load      one-cycle LFSR load strobe
//   lfsr_seed      seed presented with lfsr_load; holds the last loaded seed
//   busy           high in every state except IDLE
//   roll_valid     one-cycle pulse when die1/die2/sum are new
//   die1, die2     die values 1..6
//   sum            die1 + die2
module dice_roll_ctrl #(
  parameter int unsigned STEPS_PER_DRAW = 8,
  parameter int unsigned MAX_REJECT     = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       seed_req,
  input  logic [7:0] seed_in,
  input  logic       roll_req,
  input  logic [7:0] lfsr_num,
  output logic       lfsr_clock_en,
  output logic       lfsr_load,
  output logic [7:0] lfsr_seed,
  output logic       busy,
  output logic       roll_valid,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum
);

  typedef enum logic [2:0] {StIdle, StLoad, StStep, StSample, StDone} state_e;

  localparam logic [3:0] StepReload = 4'(STEPS_PER_DRAW - 1);
  localparam logic [2:0] MaxReject  = 3'(MAX_REJECT);

  state_e     state_q, state_d;
  logic [3:0] step_cnt_q, step_cnt_d;
  logic [2:0] rej_cnt_q, rej_cnt_d;
  logic       die_idx_q, die_idx_d;
  logic [2:0] die1_nxt_q, die1_nxt_d;
  logic [2:0] die2_nxt_q, die2_nxt_d;
  logic [7:0] seed_q, seed_d;
  logic [2:0] die1_q, die1_d;
  logic [2:0] die2_q, die2_d;
  logic [3:0] sum_q, sum_d;
  logic       roll_valid_q, roll_valid_d;

  logic [2:0] sample_v;
  logic       sample_rej;
  logic [2:0] accept_v;

  // Only the low three bits feed the die draw.
  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr_num[7:3];

  always_comb begin
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    rej_cnt_d    = rej_cnt_q;
    die_idx_d    = die_idx_q;
    die1_nxt_d   = die1_nxt_q;
    die2_nxt_d   = die2_nxt_q;
    seed_d       = seed_q;
    die1_d       = die1_q;
    die2_d       = die2_q;
    sum_d        = sum_q;
    roll_valid_d = 1'b0;

    sample_v   = lfsr_num[2:0];
    sample_rej = (sample_v == 3'd0) || (sample_v == 3'd7);
    // Forced value once the reject budget is spent: 0 -> 1, 7 -> 6.
    if (sample_rej) begin
      accept_v = (sample_v == 3'd0) ? 3'd1 : 3'd6;
    end else begin
      accept_v = sample_v;
    end

    unique case (state_q)
      StIdle: begin
        // A reseed wins over a simultaneous roll request; the roll is dropped.
        if (seed_req) begin
          seed_d  = (seed_in == 8'h00) ? 8'h01 : seed_in;
          state_d = StLoad;
        end else if (roll_req) begin
          step_cnt_d = StepReload;
          die_idx_d  = 1'b0;
          rej_cnt_d  = 3'd0;
          state_d    = StStep;
        end
      end
      StLoad: begin
        state_d = StIdle;
      end
      StStep: begin
        if (step_cnt_q == 4'd0) begin
          state_d = StSample;
        end else begin
          step_cnt_d = step_cnt_q - 4'd1;
        end
      end
      StSample: begin
        if (sample_rej && (rej_cnt_q < MaxReject)) begin
          rej_cnt_d  = rej_cnt_q + 3'd1;
          step_cnt_d = StepReload;
          state_d    = StStep;
        end else if (!die_idx_q) begin
          die1_nxt_d = accept_v;
          die_idx_d  = 1'b1;
          rej_cnt_d  = 3'd0;
          step_cnt_d = StepReload;
          state_d    = StStep;
        end else begin
          die2_nxt_d = accept_v;
          state_d    = StDone;
        end
      end
      StDone: begin
        die1_d       = die1_nxt_q;
        die2_d       = die2_nxt_q;
        sum_d        = {1'b0, die1_nxt_q} + {1'b0, die2_nxt_q};
        roll_valid_d = 1'b1;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      step_cnt_q   <= 4'd0;
      rej_cnt_q    <= 3'd0;
      die_idx_q    <= 1'b0;
      die1_nxt_q   <= 3'd0;
      die2_nxt_q   <= 3'd0;
      seed_q       <= 8'h01;
      die1_q       <= 3'd0;
      die2_q       <= 3'd0;
      sum_q        <= 4'd0;
      roll_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      rej_cnt_q    <= rej_cnt_d;
      die_idx_q    <= die_idx_d;
      die1_nxt_q   <= die1_nxt_d;
      die2_nxt_q   <= die2_nxt_d;
      seed_q       <= seed_d;
      die1_q       <= die1_d;
      die2_q       <= die2_d;
      sum_q        <= sum_d;
      roll_valid_q <= roll_valid_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign lfsr_load  = (state_q == StLoad);
  assign lfsr_seed  = seed_q;
  assign roll_valid = roll_valid_q;
  assign die1       = die1_q;
  assign die2       = die2_q;
  assign sum        = sum_q;

`ifdef DICE_FREERUN_EN
  assign lfsr_clock_en = (state_q == StStep) || (state_q == StIdle);
`else
  assign lfsr_clock_en = (state_q == StStep);
`endif

endmodule

// File: tb/tb_dice_roll_ctrl.sv
module tb_dice_roll_ctrl;

  localparam int unsigned S   = 8;
  localparam int unsigned MR  = 3;
  localparam int unsigned S2  = 3;
  localparam int unsigned MR2 = 2;

`ifdef DICE_FREERUN_EN
  localparam bit FreeRun = 1'b1;
`else
  localparam bit FreeRun = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn;
  logic       seed_req, roll_req;
  logic [7:0] seed_in;
  logic [7:0] lfsr_num;
  logic       lfsr_clock_en, lfsr_load, busy, roll_valid;
  logic [7:0] lfsr_seed;
  logic [2:0] die1, die2;
  logic [3:0] sum;

  logic       roll_req2;
  logic       seed_req2;
  logic [7:0] seed_in2;
  logic [7:0] lfsr_num2;
  logic       lfsr_clock_en2, lfsr_load2, busy2, roll_valid2;
  logic [7:0] lfsr_seed2;
  logic [2:0] die1_2, die2_2;
  logic [3:0] sum2;

  int errors = 0;
  int checks = 0;

  dice_roll_ctrl #(.STEPS_PER_DRAW(S), .MAX_REJECT(MR)) u_dut (
    .clock(clock), .resetn(resetn), .seed_req(seed_req), .seed_in(seed_in),
    .roll_req(roll_req), .lfsr_num(lfsr_num), .lfsr_clock_en(lfsr_clock_en),
    .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .busy(busy), .roll_valid(roll_valid),
    .die1(die1), .die2(die2), .sum(sum)
  );

  dice_roll_ctrl #(.STEPS_PER_DRAW(S2), .MAX_REJECT(MR2)) u_dut2 (
    .clock(clock), .resetn(resetn), .seed_req(seed_req2), .seed_in(seed_in2),
    .roll_req(roll_req2), .lfsr_num(lfsr_num2), .lfsr_clock_en(lfsr_clock_en2),
    .lfsr_load(lfsr_load2), .lfsr_seed(lfsr_seed2), .busy(busy2), .roll_valid(roll_valid2),
    .die1(die1_2), .die2(die2_2), .sum(sum2)
  );

  // External LFSR environment: a real maximal 8-bit LFSR, or a script that
  // presents script[n] at the n-th SAMPLE (one entry per S advances).
  logic [7:0]  lfsr_q = 8'h01;
  int unsigned pulse_cnt = 0;
  int unsigned script_base = 0;
  bit          script_mode = 1'b0;
  logic [2:0]  script [0:7];
  int unsigned sidx;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  always @(posedge clock) begin
    if (lfsr_load) begin
      lfsr_q <= lfsr_seed;
    end else if (lfsr_clock_en) begin
      lfsr_q    <= lfsr_step(lfsr_q);
      pulse_cnt <= pulse_cnt + 1;
    end
  end

  always_comb begin
    sidx = (pulse_cnt - script_base) / S;
    if (sidx > 7) sidx = 7;
    lfsr_num = script_mode ? {5'b00000, script[sidx[2:0]]} : lfsr_q;
  end

  // Reference: predict a roll from the LFSR state using the draw rules.
  function automatic void model_roll(inout logic [7:0] st, output logic [2:0] d1,
                                     output logic [2:0] d2, output int lat);
    int         rej_total;
    int         rej;
    bit         got;
    logic [2:0] v;
    logic [2:0] vals [2];
    rej_total = 0;
    for (int d = 0; d < 2; d++) begin
      rej = 0;
      got = 1'b0;
      while (!got) begin
        for (int k = 0; k < int'(S); k++) st = lfsr_step(st);
        v = st[2:0];
        if (v >= 3'd1 && v <= 3'd6) begin
          vals[d] = v;
          got = 1'b1;
        end else if (rej < int'(MR)) begin
          rej++;
          rej_total++;
        end else begin
          vals[d] = (v == 3'd0) ? 3'd1 : 3'd6;
          got = 1'b1;
        end
      end
    end
    d1  = vals[0];
    d2  = vals[1];
    lat = 2 * int'(S) + 3 + rej_total * (int'(S) + 1);
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_script(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    for (int i = 0; i < 8; i++) script[i] = 3'd3;
    script[1] = a;
    script[2] = b;
    script[3] = c;
    script_base = pulse_cnt;
    script_mode = 1'b1;
  endtask

  // Starts a roll at a negedge; lat = edge index of the roll_valid cycle, -1 on timeout.
  task automatic do_roll(output int lat, output int ce_cnt, output logic busy0,
                         output logic [2:0] d1, output logic [2:0] d2, output logic [3:0] sm);
    roll_req = 1'b1;
    tick();
    roll_req = 1'b0;
    busy0  = busy;
    ce_cnt = int'(lfsr_clock_en);
    lat    = -1;
    d1 = 3'd0; d2 = 3'd0; sm = 4'd0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (roll_valid) begin
        lat = k;
        d1 = die1; d2 = die2; sm = sum;
        break;
      end
      ce_cnt += int'(lfsr_clock_en);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; seed_req = 1'b0; roll_req = 1'b0; seed_in = 8'h00;
    roll_req2 = 1'b0; seed_req2 = 1'b0; seed_in2 = 8'h00; lfsr_num2 = 8'h00;
    tick(); tick();
    resetn = 1'b1;
    tick();
    checks++;
    if ({busy, lfsr_clock_en, lfsr_load, roll_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {busy, lfsr_clock_en, lfsr_load, roll_valid});
    end
    checks++;
    if ({die1, die2, sum} !== 10'd0) begin
      errors++;
      $display("FAIL reset_dice: got %0d/%0d/%0d want 0/0/0", die1, die2, sum);
    end
    checks++;
    if (lfsr_seed !== 8'h01) begin
      errors++;
      $display("FAIL reset_seed: got %h want 01", lfsr_seed);
    end
    checks++;
    if (lfsr_clock_en !== FreeRun) begin
      errors++;
      $display("FAIL idle_clock_en: got %b want %b", lfsr_clock_en, FreeRun);
    end
  endtask

  task automatic test_zero_seed();
    seed_in  = 8'h00;
    seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    checks++;
    if ({lfsr_load, busy, lfsr_seed} !== {2'b11, 8'h01}) begin
      errors++;
      $display("FAIL zero_seed_load: got load=%b busy=%b seed=%h want 1 1 01",
               lfsr_load, busy, lfsr_seed);
    end
    tick();
    checks++;
    if ({lfsr_load, busy, lfsr_seed} !== {2'b00, 8'h01}) begin
      errors++;
      $display("FAIL zero_seed_after: got load=%b busy=%b seed=%h want 0 0 01",
               lfsr_load, busy, lfsr_seed);
    end
  endtask

  task automatic test_basic_roll();
    int lat, ce; logic b0; logic [2:0] d1, d2; logic [3:0] sm;
    set_script(3'd3, 3'd5, 3'd3);
    do_roll(lat, ce, b0, d1, d2, sm);
    checks++;
    if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", b0); end
    checks++;
    if (lat != 2 * int'(S) + 3) begin
      errors++; $display("FAIL basic_latency: got %0d want %0d", lat, 2 * S + 3);
    end
    checks++;
    if ({d1, d2, sm} !== {3'd3, 3'd5, 4'd8}) begin
      errors++; $display("FAIL basic_dice: got %0d/%0d/%0d want 3/5/8", d1, d2, sm);
    end
    checks++;
    if (ce != 2 * int'(S)) begin
      errors++; $display("FAIL basic_clock_en: got %0d want %0d", ce, 2 * S);
    end
    tick();
    checks++;
    if ({roll_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL basic_pulse: got rv=%b busy=%b want 0 0", roll_valid, busy);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({die1, die2, sum} !== {3'd3, 3'd5, 4'd8}) begin
      errors++; $display("FAIL basic_hold: got %0d/%0d/%0d want 3/5/8", die1, die2, sum);
    end
  endtask

  task automatic test_rejection();
    int lat, ce; logic b0; logic [2:0] d1, d2; logic [3:0] sm;
    set_script(3'd7, 3'd2, 3'd4);
    do_roll(lat, ce, b0, d1, d2, sm);
    checks++;
    if (lat != 2 * int'(S) + 3 + int'(S) + 1) begin
      errors++; $display("FAIL reject_latency: got %0d want %0d", lat, 3 * S + 4);
    end
    checks++;
    if ({d1, d2, sm} !== {3'd2, 3'd4, 4'd6}) begin
      errors++; $display("FAIL reject_dice: got %0d/%0d/%0d want 2/4/6", d1, d2, sm);
    end
  endtask

  task automatic test_forced();
    logic [7:0] raw [2];
    logic [2:0] want;
    int lat, ce;
    raw[0] = 8'h00;
    raw[1] = 8'hF7;
    for (int r = 0; r < 2; r++) begin
      want = (r == 0) ? 3'd1 : 3'd6;
      lfsr_num2 = raw[r];
      roll_req2 = 1'b1;
      tick();
      roll_req2 = 1'b0;
      ce  = int'(lfsr_clock_en2);
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
        tick();
        if (roll_valid2) begin lat = k; break; end
        ce += int'(lfsr_clock_en2);
      end
      checks++;
      if (lat != 2 * int'(S2) + 3 + 2 * int'(MR2) * (int'(S2) + 1)) begin
        errors++; $display("FAIL forced_latency: got %0d want %0d", lat,
                           2 * S2 + 3 + 2 * MR2 * (S2 + 1));
      end
      checks++;
      if ({die1_2, die2_2, sum2} !== {want, want, 4'({1'b0, want} + {1'b0, want})}) begin
        errors++; $display("FAIL forced_dice: got %0d/%0d/%0d want %0d/%0d/%0d",
                           die1_2, die2_2, sum2, want, want, 2 * want);
      end
      checks++;
      if (ce != 2 * (int'(MR2) + 1) * int'(S2)) begin
        errors++; $display("FAIL forced_clock_en: got %0d want %0d", ce, 2 * (MR2 + 1) * S2);
      end
      checks++;
      if ({lfsr_load2, lfsr_seed2} !== {1'b0, 8'h01}) begin
        errors++; $display("FAIL forced_seed: got load=%b seed=%h", lfsr_load2, lfsr_seed2);
      end
      tick();
      checks++;
      if ({busy2, roll_valid2} !== 2'b00) begin
        errors++; $display("FAIL forced_idle: got busy=%b rv=%b", busy2, roll_valid2);
      end
    end
  endtask

  task automatic test_priority();
    int rv_cnt, ce_cnt;
    set_script(3'd1, 3'd1, 3'd1);
    seed_in  = 8'h5A;
    seed_req = 1'b1;
    roll_req = 1'b1;
    tick();
    seed_req = 1'b0;
    roll_req = 1'b0;
    checks++;
    if ({lfsr_load, busy, lfsr_seed} !== {2'b11, 8'h5A}) begin
      errors++; $display("FAIL prio_load: got load=%b busy=%b seed=%h want 1 1 5a",
                         lfsr_load, busy, lfsr_seed);
    end
    rv_cnt = 0; ce_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      rv_cnt += int'(roll_valid);
      ce_cnt += int'(lfsr_clock_en | busy);
    end
    checks++;
    if (rv_cnt != 0 || ce_cnt != 0) begin
      errors++; $display("FAIL prio_no_roll: got rv=%0d active=%0d want 0 0", rv_cnt, ce_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int rv_cnt;
    logic [7:0] seed_before;
    seed_before = lfsr_seed;
    set_script(3'd1, 3'd6, 3'd3);
    roll_req = 1'b1;
    tick();
    roll_req = 1'b0;
    rv_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 3) begin
        roll_req = 1'b1; seed_req = 1'b1; seed_in = 8'hAA;
      end else begin
        roll_req = 1'b0; seed_req = 1'b0;
      end
      tick();
      rv_cnt += int'(roll_valid);
    end
    checks++;
    if (rv_cnt != 1) begin
      errors++; $display("FAIL busy_one_valid: got %0d want 1", rv_cnt);
    end
    checks++;
    if ({lfsr_seed, sum} !== {seed_before, 4'd7}) begin
      errors++; $display("FAIL busy_ignored: got seed=%h sum=%0d want %h 7",
                         lfsr_seed, sum, seed_before);
    end
  endtask

  task automatic test_random();
    logic [7:0] st, sd;
    logic [2:0] e1, e2, d1, d2;
    logic [3:0] sm;
    int elat, lat, ce;
    logic b0;
    script_mode = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sd = 8'($urandom_range(0, 255));
      if (s == 0) sd = 8'h00;
      seed_in  = sd;
      seed_req = 1'b1;
      tick();
      seed_req = 1'b0;
      tick();
      st = (sd == 8'h00) ? 8'h01 : sd;
      for (int r = 0; r < 6; r++) begin
        model_roll(st, e1, e2, elat);
        do_roll(lat, ce, b0, d1, d2, sm);
        checks++;
        if (lat != elat || {d1, d2, sm} !== {e1, e2, 4'({1'b0, e1} + {1'b0, e2})}) begin
          errors++;
          $display("FAIL random_roll: seed=%h got lat=%0d %0d/%0d/%0d want lat=%0d %0d/%0d",
                   sd, lat, d1, d2, sm, elat, e1, e2);
        end
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end
    end
  endtask

  task automatic test_reset_mid_step();
    int rv_cnt;
    set_script(3'd4, 3'd4, 3'd4);
    roll_req = 1'b1;
    tick();
    roll_req = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({busy, lfsr_clock_en} !== 2'b11) begin
      errors++; $display("FAIL midreset_pre: got busy=%b ce=%b want 1 1", busy, lfsr_clock_en);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, lfsr_load, roll_valid, die1, die2, sum, lfsr_seed} !== {3'b000, 10'd0, 8'h01}) begin
      errors++; $display("FAIL midreset_outs: got busy=%b dice=%0d/%0d/%0d seed=%h",
                         busy, die1, die2, sum, lfsr_seed);
    end
    checks++;
    if (lfsr_clock_en !== FreeRun) begin
      errors++; $display("FAIL midreset_ce: got %b want %b", lfsr_clock_en, FreeRun);
    end
    @(negedge clock);
    resetn = 1'b1;
    rv_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      rv_cnt += int'(roll_valid | busy);
    end
    checks++;
    if (rv_cnt != 0) begin
      errors++; $display("FAIL midreset_no_valid: got %0d active cycles want 0", rv_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_zero_seed();
    test_basic_roll();
    test_rejection();
    test_forced();
    test_priority();
    test_back_to_back();
    test_random();
    test_reset_mid_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Sequencing controller for the 8-bit dice LFSR in the craps datapath. On a roll request it steps the external LFSR a fixed number of times per die, samples the low three bits, and rejection-samples them into two fair die values 1..6. It also owns LFSR reseeding: it loads a zero-safe seed and reports the finished roll with a one-cycle valid pulse to the game FSM.

## Interface
- STEPS_PER_DRAW, 8: LFSR advances per draw attempt; legal range 1..15.
- MAX_REJECT, 3: rejected samples allowed per die before a forced value is used; legal range 0..7.

- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- seed_req  in  1  single-cycle pulse; reseed the LFSR from seed_in.
- seed_in  in  8  seed value, sampled with seed_req.
- roll_req  in  1  single-cycle pulse; start a roll.
- lfsr_num  in  8  current LFSR state.
- lfsr_clock_en  out  1  advance enable to the LFSR.
- lfsr_load  out  1  one-cycle load strobe to the LFSR seed path.
- lfsr_seed  out  8  seed value presented with lfsr_load.
- busy  out  1  high in every state except IDLE.
- roll_valid  out  1  one-cycle pulse; die1, die2 and sum are new.
- die1  out  3  first die, 1..6.
- die2  out  3  second die, 1..6.
- sum  out  4  die1+die2, 2..12.

## Operation
- States: IDLE, LOAD, STEP, SAMPLE, DONE. Outputs are decoded from the state and registers only.
- IDLE
  - seed_req: latch seed_in, go to LOAD. A seed of 8'h00 is replaced by 8'h01 to avoid LFSR lock-up.
  - roll_req: go to STEP with step_cnt=STEPS_PER_DRAW-1, die_idx=0, rej_cnt=0.
  - seed_req has priority when both arrive together; that roll_req is dropped.
- LOAD: lfsr_load=1 and lfsr_seed=latched seed for one cycle, then back to IDLE.
- STEP: lfsr_clock_en=1. Decrement step_cnt; at step_cnt==0 go to SAMPLE. The LFSR advances exactly STEPS_PER_DRAW times per visit.
- SAMPLE: lfsr_clock_en=0. Let v=lfsr_num[2:0].
  - v in 1..6: accept v.
  - v is 0 or 7 and rej_cnt<MAX_REJECT: increment rej_cnt, reload step_cnt, go back to STEP.
  - v is 0 or 7 and rej_cnt==MAX_REJECT: force v=0 to 1 and v=7 to 6, then accept.
  - Accept with die_idx=0: store the value into die1_nxt, set die_idx=1, clear rej_cnt, reload step_cnt, go to STEP.
  - Accept with die_idx=1: store the value into die2_nxt, go to DONE.
- DONE: die1, die2 and sum update from the internal registers, roll_valid=1 for one cycle, then IDLE.
- roll_req and seed_req are ignored while busy. They are not queued.
- die1, die2 and sum hold their values until the next DONE.
- lfsr_seed holds the last loaded seed between loads.

## Timing
- Reset values: state IDLE; lfsr_clock_en, lfsr_load, busy and roll_valid are 0; lfsr_seed=8'h01; die1, die2 and sum are 0; all counters are 0.
- resetn asserted mid-roll aborts the roll immediately. No roll_valid is produced and the outputs go to their reset values.
- With S=STEPS_PER_DRAW and roll_req sampled at edge 0:
  - busy rises after edge 0.
  - roll_valid is high in the cycle following edge 2S+3, with no rejections.
  - Each rejection adds S+1 cycles. Worst case is 2S+3+2*MAX_REJECT*(S+1).
- Reseed: lfsr_load is high for exactly the cycle following the seed_req edge, and busy is high for that same cycle.
- SAMPLE reads lfsr_num one full cycle after the last STEP edge. The external LFSR must be registered so that lfsr_num is stable at that point.

## Configuration
- DICE_FREERUN_EN defined:
  - lfsr_clock_en=1 in IDLE as well, so the LFSR free-runs between rolls and roll values depend on player timing.
  - LOAD still forces lfsr_clock_en=0.
- DICE_FREERUN_EN undefined: lfsr_clock_en=0 in IDLE. Rolls are fully deterministic from the seed, which is the required mode for directed tests.
- All test-plan scenarios assume DICE_FREERUN_EN is undefined, except where stated.

## Test plan
- Zero seed: seed_req with seed_in=8'h00 gives a single lfsr_load pulse with lfsr_seed=8'h01 and busy high for 1 cycle.
- Basic roll: S=8, bench-scripted lfsr_num low bits 3'd3 at the first SAMPLE and 3'd5 at the second. Required: die1=3, die2=5, sum=8, roll_valid at edge 19, exactly 16 lfsr_clock_en cycles.
- Rejection: scripted samples 7, 2, 4. Required: die1=2, die2=4, sum=6, roll_valid at edge 28.
- Forced value: MAX_REJECT=2, sample 0 held constant. Required: die1=1, die2=1, sum=2 after 3 SAMPLE visits per die.
- Priority and busy: seed_req and roll_req in the same cycle give LOAD only. A roll_req during STEP gives exactly one roll_valid.
- Reset mid-STEP: resetn pulled low gives all outputs 0 and no roll_valid. With DICE_FREERUN_EN defined, lfsr_clock_en=1 in IDLE.
